// File: rtl/mux_ctrl_pkg.sv
// Shared types and the rotate-priority pick used by the 4:1 mux arbiter.
// rr_pick returns {found, idx}: the first valid index at or above ptr, modulo 4.
package mux_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    // Scan from farthest to nearest so the nearest valid index is the last one written.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (valid[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority encoder over four requesters.
module rr_pick4
  import mux_ctrl_pkg::*;
(
  input  logic [3:0] valid_i,
  input  logic [1:0] ptr_i,
  output logic       found_o,
  output logic [1:0] idx_o
);

  assign {found_o, idx_o} = rr_pick(valid_i, ptr_i);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter driving a registered 4:1 mux select; the grant is held
// until the burst ends on in_last or after MAX_BEATS beats, then priority rotates.
module mux4_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [3:0]         in_last,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic               out_last,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [1:0]         sel,
  output logic               busy
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick_found;
  logic [1:0]       pick_idx;
  logic             xfer;
  logic [WIDTH-1:0] data_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign data_arr[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick4 u_pick (
    .valid_i (in_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    in_ready  = 4'b0000;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        out_valid       = in_valid[sel_q];
        out_data        = data_arr[sel_q];
        out_last        = in_last[sel_q] | (cnt_q == LAST_CNT);
        in_ready[sel_q] = out_ready;
        xfer            = out_valid & out_ready;
        // A dropped in_valid merely stalls the burst; only a last transfer releases it.
        if (xfer) begin
          if (out_last) begin
            ptr_d   = sel_q + 2'd1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel  = sel_q;
  assign busy = (state_q == GRANT);

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and select controller for the 4:1 single-bit multiplexer datapath (MUX4T1_1 family), generalised to WIDTH-bit beats. It accepts valid/last/ready streams from four requesters, selects one, drives the 2-bit mux select, and locks that selection for a whole burst (up to MAX_BEATS beats) before rotating priority. It sits between four producers and one shared downstream consumer.

## Interface
- WIDTH, 1, data width per requester and at the output
- MAX_BEATS, 16, beats after which a burst is forcibly ended; must be ≥ 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  4  per-requester beat valid
- in_last  input  4  per-requester last-beat-of-burst flag
- in_data  input  4*WIDTH  requester i in bits [i*WIDTH +: WIDTH]
- in_ready  output  4  per-requester accept
- out_valid  output  1  output beat valid
- out_last  output  1  end of granted burst (in_last, or forced by MAX_BEATS)
- out_data  output  WIDTH  selected data
- out_ready  input  1  downstream accept
- sel  output  2  mux select (registered), index of granted requester
- busy  output  1  high in GRANT state

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if any in_valid is high, pick the first valid index scanning from ptr upward modulo 4; register it into sel and go to GRANT next cycle. If none valid, stay in IDLE.
- GRANT: out_valid = in_valid[sel]; out_data = in_data[sel]; in_ready[sel] = out_ready; every other in_ready bit is 0.
- Beat transfer = out_valid & out_ready. On each transfer beat_cnt increments.
- Burst end: a transfer where in_last[sel] is 1, or beat_cnt == MAX_BEATS-1. out_last = in_last[sel] | (beat_cnt == MAX_BEATS-1).
- On burst end: ptr <= sel+1 (mod 4, natural 2-bit wrap 3 -> 0), beat_cnt <= 0, go to IDLE.
- In GRANT, deassertion of in_valid[sel] does not release the grant. The arbiter waits for the burst to end.
- beat_cnt width is clog2(MAX_BEATS), minimum 1 bit. With MAX_BEATS = 1, every beat ends its burst.
- Reset values: state IDLE, sel 0, ptr 0, beat_cnt 0, busy 0. All outputs are 0: out_valid, out_last, out_data and in_ready.

## Timing
- Arbitration latency: request in IDLE at cycle n, grant (sel/busy valid) at n+1, first transfer possible at n+1.
- Minimum gap between bursts is one IDLE cycle. Sustained throughput is 1 beat/cycle within a burst.
- The data/valid/ready path in GRANT is combinational: in_ready depends on out_ready the same cycle.
- sel changes only on the IDLE->GRANT edge, so it is glitch-free for the mux.
- Asynchronous reset mid-burst drops the grant immediately and discards the in-flight burst. No beat is transferred in the reset cycle.

## Structure
- Shared package mux_ctrl_pkg holds the state enum (IDLE, GRANT) and a function rr_pick(valid[3:0], ptr[1:0]) returning {found, idx[1:0]}.
- One sub-module: rr_pick4, the combinational rotate-priority encoder. The FSM, counter and data mux live in the top.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1 -> in_ready=0, out_valid=0, sel=0. After release, grant goes to requester 0 one cycle later.
- Fairness: all four valid, 1-beat bursts (in_last=1), out_ready=1 -> sel sequence 0,1,2,3,0 with one IDLE cycle between grants.
- Skip and wrap: ptr=2, only requesters 1 and 3 valid -> grant 3, then 1 (wrap 3 -> 0 -> 1).
- Backpressure: 3-beat burst from requester 2 with out_ready low for 4 cycles mid-burst -> sel stays 2, no beats lost or duplicated, out_last on the third transfer.
- Forced release: MAX_BEATS=4, requester 0 streams 10 beats without last -> out_last on beat 4, then grant moves to another valid requester (requester 1 if valid).
- Reset mid-burst: assert rst_n=0 at beat 2 of a 5-beat burst -> busy=0 and in_ready=0 immediately. After release, arbitration restarts from ptr 0.
